// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte word assembler. Byte index wraps 3 -> 0 on its own,
// so a full word simply starts the next one without an explicit clear.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] idx;

    // The byte being loaded right now completes the word.
    assign word_full = load && (idx == 2'd3);

    // Place each incoming byte at its lane; least significant byte arrives first.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= 32'd0;
            idx  <= 2'd0;
        end else if (load) begin
            word[{idx, 3'b000} +: 8] <= byte_in;
            idx                      <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed UART bytes -> 32-bit RAM writes,
// holding the CPU in reset until a checksum-verified image is resident.
//
//   state | meaning
//   IDLE  | hunting for the sync byte, other bytes discarded
//   LEN   | next byte is the word count N
//   DATA  | collecting data bytes into the current word
//   WRITE | single-cycle RAM write strobe, input stalled
//   CSUM  | next byte is compared with the running XOR
//   DONE  | image verified, CPU released
//   ERR   | frame rejected, CPU still held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int FW_LENGTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t     state;
    logic [7:0] n_len;
    logic [7:0] word_cnt;
    logic [7:0] csum;
    logic       accept;
    logic       len_bad;
    logic       is_sync;
    logic       word_full;

    assign accept  = rx_valid && rx_ready;
    assign is_sync = (rx_data == SYNC_BYTE);
    assign len_bad = (rx_data == 8'd0) || (int'(rx_data) > FW_LENGTH);

    // The packer's register feeds wr_data directly, so the word is already
    // registered and stable during the WRITE cycle.
    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept && (state == LEN)),
        .load      (accept && (state == DATA)),
        .byte_in   (rx_data),
        .word      (wr_data),
        .word_full (word_full)
    );

    // Frame sequencing, counters, checksum and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            n_len    <= 8'd0;
            word_cnt <= 8'd0;
            csum     <= 8'd0;
        end else begin
            wr_en    <= 1'b0;
            rx_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && is_sync) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (len_bad) begin
                            error <= 1'b1;
                            state <= ERR;
                        end else begin
                            n_len    <= rx_data;
                            word_cnt <= 8'd0;
                            csum     <= 8'd0;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        if (word_full) begin
                            // Stall input for the write cycle so no byte is lost.
                            state    <= WRITE;
                            wr_en    <= 1'b1;
                            wr_addr  <= {22'd0, word_cnt, 2'b00};
                            rx_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 8'd1;
                    if ((word_cnt + 8'd1) == n_len) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= DONE;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                DONE, ERR: begin
                    if (accept && is_sync) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        state    <= LEN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are generated (fixed and random),
// expected RAM writes are queued from a frame-level model, and a monitor
// pops and compares them whenever wr_en is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.FW_LENGTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  sent = 0;
    int  accepted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count real handshakes (reset blocks acceptance).
    always @(posedge clk) begin
        if (!rst && rx_valid && rx_ready) accepted <= accepted + 1;
    end

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
            check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
        end
    end

    // Present one byte (called at a negedge); returns at the negedge after transfer.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 0;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: got no rx_ready expected ready within 50 cycles");
        end
        @(negedge clk);
        sent++;
    endtask

    // Frame-level reference: N words, little-endian bytes, XOR checksum.
    task automatic run_frame(input logic [7:0] n, input logic [7:0] data [32],
                             input logic [7:0] csum_mask, input logic [7:0] pre [4],
                             input int pre_n, input bit gaps, input string tag);
        logic [7:0]  cs = 8'd0;
        logic [31:0] w;
        bit          len_ok = (n != 8'd0) && (n <= 8'd8);
        bit          exp_done;
        wr_t         e;
        if (len_ok) begin
            for (int i = 0; i < int'(n); i++) begin
                w = 32'(data[4*i]) + (32'(data[4*i+1]) << 8)
                  + (32'(data[4*i+2]) << 16) + (32'(data[4*i+3]) << 24);
                e.addr = 32'(i) * 4;
                e.data = w;
                exp_q.push_back(e);
                for (int j = 0; j < 4; j++) cs = cs ^ data[4*i+j];
            end
        end
        for (int g = 0; g < pre_n; g++) send_byte(pre[g], gaps);
        send_byte(8'hA5, gaps);
        send_byte(n, gaps);
        if (len_ok) begin
            for (int j = 0; j < 4 * int'(n); j++) send_byte(data[j], gaps);
            send_byte(cs ^ csum_mask, gaps);
        end
        rx_valid = 1'b0;
        exp_done = len_ok && (csum_mask == 8'd0);
        check({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
        check({tag, "_error"},    {31'd0, error},    {31'd0, !exp_done});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        check({tag, "_wr_addr"},  wr_addr,           32'd0);
        check({tag, "_wr_data"},  wr_data,           32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_error"},    {31'd0, error},    32'd0);
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals({tag, "_first_cycle"});
        @(negedge clk);
        check({tag, "_rx_ready_rise"}, {31'd0, rx_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] s1 [32]   = '{0: 8'h13, 4: 8'h93, 6: 8'h10, default: 8'h00};
        logic [7:0] s4 [32]   = '{0: 8'hEF, 1: 8'hBE, 2: 8'hAD, 3: 8'hDE, default: 8'h00};
        logic [7:0] none [4]  = '{default: 8'h00};
        logic [7:0] garb [4]  = '{0: 8'hFF, 1: 8'h00, 2: 8'h5A, default: 8'h00};
        logic [7:0] rd [32];
        logic [7:0] rp [4];
        logic [7:0] n;
        logic [7:0] mask;
        int         kind;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        release_reset("reset");

        // Fixed scenarios.
        run_frame(8'd2, s1, 8'h00, none, 0, 1'b0, "good_frame");
        run_frame(8'd2, s1, 8'h01, none, 0, 1'b0, "bad_csum");
        run_frame(8'd2, s1, 8'h00, none, 0, 1'b0, "recover");
        run_frame(8'd0, s1, 8'h00, none, 0, 1'b0, "len_zero");
        run_frame(8'd9, s1, 8'h00, none, 0, 1'b0, "len_nine");
        run_frame(8'd1, s4, 8'h00, garb, 3, 1'b0, "garbage");
        run_frame(8'd2, s1, 8'h00, none, 0, 1'b1, "gapped");
        run_frame(8'd8, s1, 8'h00, none, 0, 1'b0, "max_len");

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            for (int j = 0; j < 32; j++) rd[j] = 8'($urandom_range(0, 255));
            for (int j = 0; j < 4; j++) begin
                rp[j] = 8'($urandom_range(0, 255));
                if (rp[j] == 8'hA5) rp[j] = 8'h3C;
            end
            kind = $urandom_range(0, 3);
            n    = 8'($urandom_range(1, 8));
            mask = 8'h00;
            if (kind == 2) mask = 8'h01 << $urandom_range(0, 7);
            if (kind == 3) n = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
            run_frame(n, rd, mask, rp, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end

        // Reset while the word-completing byte is presented: it must be dropped.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        release_reset("mid_reset");
        check("mid_reset_pending_writes", exp_q.size(), 32'd0);
        run_frame(8'd2, s1, 8'h00, none, 0, 1'b0, "resend");

        repeat (5) @(negedge clk);
        check("leftover_writes", exp_q.size(), 32'd0);
        check("bytes_consumed", accepted, sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
